fpu_result_scoreboard: RTL

- Parametrised, latency-aligned result checker for the FPU, bound alongside the fpu instance in dynamic simulation.
- Takes golden result and exception flags from the bench, delays them LATENCY cycles to line up with the DUT pipeline, then compares per field with defined X handling.
- Keeps saturating compare/mismatch/skip counters and captures the first failure for debug.
- Replaces per-cycle immediate comparison with a stateful, pipelined, reset-aware scoreboard.

---
 rtl/fpu_result_scoreboard_if.sv | 44 ++++
 rtl/fpu_result_scoreboard.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_scoreboard_if.sv
// rtl/fpu_result_scoreboard_if.sv - golden/DUT sample bundle and checker status for fpu_result_scoreboard
//
// Purpose: groups the checker's stimulus side (enable, golden sample, DUT sample,
//          flag mask) and its status side (mismatch pulse, counters, first-failure
//          capture, halted) into one bundle.
// Modports:
//   master - testbench side: drives chk_en/exp_*/exc_mask/dut_*, reads status
//   slave  - checker side: reads chk_en/exp_*/exc_mask/dut_*, drives status
interface fpu_result_scoreboard_if #(
    parameter int WIDTH = 32,
    parameter int EXC_W = 5,
    parameter int CNT_W = 16
);
    logic             chk_en;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_out;
    logic [EXC_W-1:0] exp_exc;
    logic [EXC_W-1:0] exc_mask;
    logic [WIDTH-1:0] dut_out;
    logic [EXC_W-1:0] dut_exc;

    logic             mismatch;
    logic [EXC_W:0]   mismatch_field;
    logic [CNT_W-1:0] cmp_count;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] skip_count;
    logic             first_err_valid;
    logic [CNT_W-1:0] first_err_index;
    logic [WIDTH-1:0] first_err_got;
    logic [WIDTH-1:0] first_err_exp;
    logic             halted;

    modport master (
        output chk_en, exp_valid, exp_out, exp_exc, exc_mask, dut_out, dut_exc,
        input  mismatch, mismatch_field, cmp_count, err_count, skip_count,
               first_err_valid, first_err_index, first_err_got, first_err_exp, halted
    );

    modport slave (
        input  chk_en, exp_valid, exp_out, exp_exc, exc_mask, dut_out, dut_exc,
        output mismatch, mismatch_field, cmp_count, err_count, skip_count,
               first_err_valid, first_err_index, first_err_got, first_err_exp, halted
    );
endinterface

// File: rtl/fpu_result_scoreboard.sv
// rtl/fpu_result_scoreboard.sv - latency-aligned golden vs DUT result checker for the FPU
//
// Purpose: delays the golden result/flags LATENCY cycles, compares them per field
//          against the DUT with X/Z-aware rules, keeps saturating compare/error/skip
//          counters and captures the first failing compare.
// Ports:
//   clk - sampling clock, rising edge
//   rst - asynchronous active-high reset
//   sb  - fpu_result_scoreboard_if.slave: chk_en, exp_valid/exp_out/exp_exc,
//         exc_mask, dut_out/dut_exc in; mismatch, mismatch_field, cmp_count,
//         err_count, skip_count, first_err_*, halted out
// Optional feature macro: FPU_SCOREBOARD_STOP_ON_FAIL_EN
//   defined   - first failing compare halts the checker until rst, reports via $error
//   undefined - checking continues after failures, halted tied 0
module fpu_result_scoreboard #(
    parameter int WIDTH   = 32,
    parameter int EXC_W   = 5,
    parameter int LATENCY = 0,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fpu_result_scoreboard_if.slave sb
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Golden sample as it emerges from the delay line
    logic             dl_valid;
    logic [WIDTH-1:0] dl_out;
    logic [EXC_W-1:0] dl_exc;

    // Samples only enter while checking stays enabled; any other cycle flushes
    // the line so in-flight samples from before a disable are never compared.
    logic shift_en;
    assign shift_en = (state_q == S_RUN) && sb.chk_en;

    generate
        if (LATENCY == 0) begin : g_nodelay
            assign dl_valid = sb.exp_valid;
            assign dl_out   = sb.exp_out;
            assign dl_exc   = sb.exp_exc;
        end else begin : g_delay
            logic [LATENCY-1:0] v_q;
            logic [WIDTH-1:0]   o_q [LATENCY];
            logic [EXC_W-1:0]   e_q [LATENCY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= '0;
                end else if (shift_en) begin
                    v_q[0] <= sb.exp_valid;
                    for (int i = 1; i < LATENCY; i++) begin
                        v_q[i] <= v_q[i-1];
                    end
                end else begin
                    v_q <= '0;
                end
            end

            // Payload needs no reset: it is only looked at behind its valid bit
            always_ff @(posedge clk) begin
                o_q[0] <= sb.exp_out;
                e_q[0] <= sb.exp_exc;
                for (int i = 1; i < LATENCY; i++) begin
                    o_q[i] <= o_q[i-1];
                    e_q[i] <= e_q[i-1];
                end
            end

            assign dl_valid = v_q[LATENCY-1];
            assign dl_out   = o_q[LATENCY-1];
            assign dl_exc   = e_q[LATENCY-1];
        end
    endgenerate

    // Per-field compare. Reduction XOR turns any X/Z bit into X, which marks a
    // golden field as unknown. Case inequality makes an X/Z DUT bit against a
    // known golden bit count as a difference.
    logic             cmp_cycle;
    logic             res_cmp;
    logic             res_fail;
    logic [EXC_W-1:0] flag_cmp;
    logic [EXC_W-1:0] flag_fail;
    logic             any_cmp;
    logic             any_fail;
    logic [EXC_W:0]   fail_vec;

    always_comb begin
        flag_cmp  = '0;
        flag_fail = '0;
        cmp_cycle = (state_q == S_RUN) && dl_valid;
        res_cmp   = ((^dl_out) !== 1'bx);
        res_fail  = res_cmp && (sb.dut_out !== dl_out);
        for (int i = 0; i < EXC_W; i++) begin
            flag_cmp[i]  = (sb.exc_mask[i] === 1'b1) && ((^dl_exc[i]) !== 1'bx);
            flag_fail[i] = flag_cmp[i] && (sb.dut_exc[i] !== dl_exc[i]);
        end
        any_cmp  = res_cmp || (|flag_cmp);
        fail_vec = {flag_fail, res_fail};
        any_fail = |fail_vec;
    end

    // State register and next-state logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sb.chk_en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!sb.chk_en) begin
                    state_d = S_IDLE;
                end
`ifdef FPU_SCOREBOARD_STOP_ON_FAIL_EN
                // A failure wins over a simultaneous disable
                if (cmp_cycle && any_cmp && any_fail) begin
                    state_d = S_HALTED;
                end
`endif
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result registers
    logic             mismatch;
    logic [EXC_W:0]   mismatch_field;
    logic [CNT_W-1:0] cmp_count;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] skip_count;
    logic             first_err_valid;
    logic [CNT_W-1:0] first_err_index;
    logic [WIDTH-1:0] first_err_got;
    logic [WIDTH-1:0] first_err_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch        <= 1'b0;
            mismatch_field  <= '0;
            cmp_count       <= '0;
            err_count       <= '0;
            skip_count      <= '0;
            first_err_valid <= 1'b0;
            first_err_index <= '0;
            first_err_got   <= '0;
            first_err_exp   <= '0;
        end else begin
            mismatch       <= 1'b0;
            mismatch_field <= '0;
            if (cmp_cycle) begin
                if (any_cmp) begin
                    if (cmp_count != '1) begin
                        cmp_count <= cmp_count + 1'b1;
                    end
                    if (any_fail) begin
                        mismatch       <= 1'b1;
                        mismatch_field <= fail_vec;
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_index <= cmp_count;
                            first_err_got   <= sb.dut_out;
                            first_err_exp   <= dl_out;
`ifdef FPU_SCOREBOARD_STOP_ON_FAIL_EN
                            $error("fpu_result_scoreboard: compare %0d failed, got %h expected %h",
                                   cmp_count, sb.dut_out, dl_out);
`endif
                        end
                    end
                end else if (skip_count != '1) begin
                    skip_count <= skip_count + 1'b1;
                end
            end
        end
    end

    assign sb.mismatch        = mismatch;
    assign sb.mismatch_field  = mismatch_field;
    assign sb.cmp_count       = cmp_count;
    assign sb.err_count       = err_count;
    assign sb.skip_count      = skip_count;
    assign sb.first_err_valid = first_err_valid;
    assign sb.first_err_index = first_err_index;
    assign sb.first_err_got   = first_err_got;
    assign sb.first_err_exp   = first_err_exp;

`ifdef FPU_SCOREBOARD_STOP_ON_FAIL_EN
    assign sb.halted = (state_q == S_HALTED);
`else
    assign sb.halted = 1'b0;
`endif

endmodule
